// File: rtl/cache_fill_fsm.sv
// Purpose: on a cache miss, fetch the whole block from main memory, stream the words into the data array, then commit the tag.
// Latency: first read is issued the cycle after miss_detected; the tag is written in the cycle the last word returns.
// Backpressure: memory accepts one read per cycle with no stall; the cache is held off by fsm_busy for the whole fill.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS    = 8,   // 16-bit words per block, power of two, >= 2
    parameter int ADDR_W         = 16,  // byte-address width
    parameter int TIMEOUT_CYCLES = 64   // fill watchdog in cycles, 0 disables it
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    output logic                           fsm_busy,
    output logic                           mem_read_en,
    output logic [ADDR_W-1:0]              memory_address,
    input  logic                           memory_data_valid,
    input  logic [15:0]                    memory_data,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array,
    output logic [ADDR_W-1:0]              fill_tag,
    output logic                           fill_error
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    // Byte offset within a block: word index plus the byte-in-word bit.
    localparam int OFF_W = IDX_W + 1;
    // Counters must be able to hold BLOCK_WORDS itself ("all issued / all received").
    localparam int CNT_W = IDX_W + 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  NUM_WORDS  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK  = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [TMR_W-1:0]  TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             stateQ;
    state_t             stateD;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   issueCnt;
    logic [CNT_W-1:0]   recvCnt;
    logic [TMR_W-1:0]   timer;
    logic               issuing;
    logic               receiving;
    logic               completing;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state and all outputs; everything is a function of state, counters and this cycle's valid.
    always_comb begin
        stateD           = stateQ;
        issuing          = 1'b0;
        receiving        = 1'b0;
        completing       = 1'b0;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_idx    = '0;
        fill_data        = memory_data;
        write_tag_array  = 1'b0;
        fill_tag         = '0;
        fill_error       = 1'b0;
        case (stateQ)
            IDLE: begin
                if (miss_detected) begin
                    stateD = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                fill_tag = base;
                // Requests go out back to back; the sum wraps within ADDR_W.
                issuing = (issueCnt < NUM_WORDS);
                if (issuing) begin
                    mem_read_en    = 1'b1;
                    memory_address = base + ADDR_W'({issueCnt[IDX_W-1:0], 1'b0});
                end
                // Returns arrive in issue order, so the receive count is the word index.
                receiving = memory_data_valid && (recvCnt < NUM_WORDS);
                if (receiving) begin
                    write_data_array = 1'b1;
                    fill_word_idx    = recvCnt[IDX_W-1:0];
                    completing       = (recvCnt == LAST_WORD);
                end
                if (completing) begin
                    write_tag_array = 1'b1;
                    stateD          = IDLE;
                end else if ((TIMEOUT_CYCLES > 0) && (timer == TIMER_LAST)) begin
                    // A completion in the same cycle wins over the watchdog.
                    fill_error = 1'b1;
                    stateD     = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Block base and fill progress counters; a new miss in IDLE restarts them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            issueCnt <= '0;
            recvCnt  <= '0;
            timer    <= '0;
        end else if (stateQ == IDLE) begin
            if (miss_detected) begin
                base     <= miss_address & BASE_MASK;
                issueCnt <= '0;
                recvCnt  <= '0;
                timer    <= '0;
            end
        end else begin
            if (issuing) begin
                issueCnt <= issueCnt + 1'b1;
            end
            if (receiving) begin
                recvCnt <= recvCnt + 1'b1;
            end
            if (TIMEOUT_CYCLES > 0) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-service engine between a cache (I or D) and the shared multi-cycle main memory. On a cache miss it fetches the whole 16-byte block containing the miss address, one word per issue cycle. It streams the returned words into the cache data array and then commits the tag. This block is the responder side of the cache's miss_detected / fsm_busy handshake; the testbench hit/request statistics depend on it stalling the pipeline correctly.

Parameters:
BLOCK_WORDS, 8, 16-bit words per cache block; power of two; block size = 2*BLOCK_WORDS bytes
ADDR_W, 16, byte-address width
TIMEOUT_CYCLES, 64, max cycles in FILL before abort; 0 disables watchdog

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_detected  in  1  cache reports miss this cycle (level)
miss_address  in  ADDR_W  byte address of the missing access
fsm_busy  out  1  fill in progress; cache/pipeline must stall
mem_read_en  out  1  read request to memory this cycle
memory_address  out  ADDR_W  byte address of the issued read
memory_data_valid  in  1  memory returns one word this cycle (in issue order)
memory_data  in  16  returned word
write_data_array  out  1  write fill_data into data array at fill_word_idx
fill_word_idx  out  log2(BLOCK_WORDS)  word offset within block
fill_data  out  16  word to write (= memory_data, combinational pass-through)
write_tag_array  out  1  commit tag/valid for the block
fill_tag  out  ADDR_W  block base address (low offset bits zero)
fill_error  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue_cnt, recv_cnt, timer, base cleared; all outputs 0. Reset mid-FILL discards the fill. Memory returns arriving after reset are ignored because the block is IDLE. No tag write occurs.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy=0, mem_read_en=0, memory_address=0.
  - Writes are never asserted; memory_data_valid is ignored.
  - On miss_detected=1: base <= miss_address with low log2(2*BLOCK_WORDS) bits cleared; issue_cnt, recv_cnt and timer <= 0; next state FILL.
- FILL:
  - fsm_busy=1; fill_tag=base.
  - Issue: mem_read_en=1 while issue_cnt<BLOCK_WORDS; memory_address = base + 2*issue_cnt (mod 2^ADDR_W); issue_cnt increments each issue cycle. One request per cycle, no back-pressure.
  - Receive: each cycle with memory_data_valid=1 and recv_cnt<BLOCK_WORDS: write_data_array=1, fill_word_idx=recv_cnt, fill_data=memory_data; recv_cnt increments. Valid while recv_cnt==BLOCK_WORDS is ignored.
  - Completion: in the cycle the last word is received (recv_cnt==BLOCK_WORDS-1 and valid), write_data_array=1 and write_tag_array=1 together; next state IDLE. fsm_busy is 0 from the following cycle.
  - miss_detected is ignored in FILL. A miss seen in the completion cycle is not latched; the cache re-presents it.
  - Watchdog (TIMEOUT_CYCLES>0): timer increments every FILL cycle. When timer reaches TIMEOUT_CYCLES-1 without completion: fill_error=1 for that cycle, no tag write, next state IDLE.
- Timing, memory latency L: miss at cycle 0; issues cycles 1..BLOCK_WORDS; words at cycles 1+L..BLOCK_WORDS+L; tag write at BLOCK_WORDS+L; fsm_busy high cycles 1..BLOCK_WORDS+L.
- The FSM does not depend on L; it counts valids only.
- Wrap: base near 0xFFF0 addresses 0xFFF0..0xFFFE; no carry out of ADDR_W.
- fsm_busy, mem_read_en, write_data_array and write_tag_array are derived from state/counters and the current-cycle valid only. No combinational path from miss_detected to fsm_busy.

Test Plan:
- Reset 2 cycles, idle 5 -> all outputs 0; spurious memory_data_valid in IDLE produces no writes.
- miss_address=0x1236, L=4, data 0xA000+i -> reads 0x1230..0x123E on cycles 1..8; writes idx0..7 with 0xA000..0xA007 on cycles 5..12; write_tag_array at cycle 12 with fill_tag=0x1230; fsm_busy cycles 1..12 exactly.
- miss_address=0xFFFA -> memory_address 0xFFF0..0xFFFE, no wrap to 0x0000; fill_tag=0xFFF0.
- miss_detected held high through fill and for one cycle after -> exactly one fill for first miss, second fill starts the cycle after fsm_busy falls.
- Memory returns only 5 words, TIMEOUT_CYCLES=64 -> fill_error pulse at FILL cycle 63, no write_tag_array, IDLE next; new miss then completes normally.
- rst_n asserted at cycle 6 of a fill (asynchronous, mid-cycle) -> outputs 0 immediately; late valids ignored; no tag write.
